// File: rtl/mat_mult_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mat_mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Upper bounds for the width-generic helpers below; DATA_W must stay <= MAX_DATA_W.
  localparam int MAX_DATA_W = 32;
  localparam int MAX_ACC_W  = 64;

  // N products of two DATA_W values never exceed 2*DATA_W + clog2(N) bits.
  function automatic int acc_width(input int n, input int data_w);
    return 2 * data_w + $clog2(n);
  endfunction

  // Reduce a full-precision sum to a data_w-bit element: clamp when mode=1, else keep low bits.
  function automatic logic [MAX_DATA_W-1:0] sat_or_wrap(input logic [MAX_ACC_W-1:0] sum,
                                                        input logic                 mode,
                                                        input int                   data_w);
    logic [MAX_ACC_W-1:0] lim;
    lim = (MAX_ACC_W'(1) << data_w) - MAX_ACC_W'(1);
    if (mode && (sum > lim)) return MAX_DATA_W'(lim);
    return MAX_DATA_W'(sum & lim);
  endfunction

  // Element slot of [i][j] counted from the LSB end; [0][0] occupies the MSBs.
  function automatic int elem_idx(input int i, input int j, input int n);
    return n * n - 1 - (i * n + j);
  endfunction

endpackage

// File: rtl/mat_mult_seq_mac.sv
// Single multiply-accumulate slice: sum = acc + a*b, acc <= sum when enabled.
// Latency: sum is combinational, acc updates on the next rising edge.
// Backpressure: none; the caller gates progress with en and clr.
// Ports: clk/reset (sync, active-high), clr (clears acc, wins over en), en (accumulate),
//        a/b (DATA_W operands), sum (acc + a*b, combinational), acc (registered partial sum).
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic [ACC_W-1:0]  acc
);

  assign sum = acc + (ACC_W'(a) * ACC_W'(b));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential N x N unsigned matrix multiply, one MAC per cycle, wrap or saturate per op.
// Latency: out_valid rises N^3+1 cycles after the input handshake edge.
// Backpressure: holds result in DONE until out_ready; in_ready only in IDLE, no overlap.
// Ports: clk, reset (sync, active-high); in_valid/in_ready with a_in, b_in, sat_mode;
//        out_valid/out_ready with result, ovf. Matrices are row-major, [0][0] in the MSBs.
module mat_mult_seq
  import mat_mult_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = acc_width(N, DATA_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*N*DATA_W-1:0] a_in,
  input  logic [N*N*DATA_W-1:0] b_in,
  input  logic                  sat_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*N*DATA_W-1:0] result,
  output logic                  ovf
);

  localparam int               IDX_W = $clog2(N);
  localparam int               VEC_W = N * N * DATA_W;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  a_q, b_q, result_q;
  logic              sat_q, ovf_q;
  logic [IDX_W-1:0]  i_q, j_q, k_q;
  logic [DATA_W-1:0] a_elem, b_elem, wr_val;
  logic [ACC_W-1:0]  sum, acc_unused;
  logic              accept, computing, k_last, last_elem, mac_clr, elem_ovf;

  assign accept    = in_valid && in_ready;
  assign computing = (state_q == COMPUTE);
  assign k_last    = (k_q == LAST);
  assign last_elem = k_last && (j_q == LAST) && (i_q == LAST);
  // The accumulator restarts at every acceptance and after each element write.
  assign mac_clr   = accept || (computing && k_last);
  assign elem_ovf  = |sum[ACC_W-1:DATA_W];
  assign wr_val    = DATA_W'(sat_or_wrap(MAX_ACC_W'(sum), sat_q, DATA_W));

  assign result = result_q;
  assign ovf    = ovf_q;

  // Operand select: A[i][k] and B[k][j] from the latched packed matrices.
  always_comb begin
    a_elem = '0;
    b_elem = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (i_q == IDX_W'(r) && k_q == IDX_W'(c)) a_elem = a_q[elem_idx(r, c, N)*DATA_W +: DATA_W];
        if (k_q == IDX_W'(r) && j_q == IDX_W'(c)) b_elem = b_q[elem_idx(r, c, N)*DATA_W +: DATA_W];
      end
    end
  end

  mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (mac_clr),
    .en   (computing),
    .a    (a_elem),
    .b    (b_elem),
    .sum  (sum),
    .acc  (acc_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (last_elem) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      sat_q    <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_q   <= a_in;
      b_q   <= b_in;
      sat_q <= sat_mode;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      ovf_q <= 1'b0;
    end else if (computing) begin
      if (k_last) begin
        // Final partial product lands here: commit element [i][j] from the full sum.
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            if (i_q == IDX_W'(r) && j_q == IDX_W'(c)) begin
              result_q[elem_idx(r, c, N)*DATA_W +: DATA_W] <= wr_val;
            end
          end
        end
        if (elem_ovf) ovf_q <= 1'b1;
        k_q <= '0;
        if (j_q == LAST) begin
          j_q <= '0;
          i_q <= (i_q == LAST) ? '0 : i_q + IDX_W'(1);
        end else begin
          j_q <= j_q + IDX_W'(1);
        end
      end else begin
        k_q <= k_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Bench for mat_mult_seq: N=2 and N=3 instances against an arithmetic reference model.
// Latency: checks N^3+1 cycles from acceptance to out_valid.
// Backpressure: exercises out_ready stalls, ignored in_valid, back-to-back operations.
module tb_mat_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        in_valid2, in_ready2, sat2, out_valid2, out_ready2, ovf2;
  logic [31:0] a2, b2, res2;
  logic        in_valid3, in_ready3, sat3, out_valid3, out_ready3, ovf3;
  logic [71:0] a3, b3, res3;

  int compared   = 0;
  int mismatched = 0;

  mat_mult_seq #(.N(2), .DATA_W(8)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a_in(a2), .b_in(b2), .sat_mode(sat2), .out_valid(out_valid2),
    .out_ready(out_ready2), .result(res2), .ovf(ovf2)
  );

  mat_mult_seq #(.N(3), .DATA_W(8)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .a_in(a3), .b_in(b3), .sat_mode(sat3), .out_valid(out_valid3),
    .out_ready(out_ready3), .result(res3), .ovf(ovf3)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Matrix helpers: element [i][j] of an n x n byte matrix, [0][0] in the top byte.
  function automatic int get_el(input logic [71:0] v, input int i, input int j, input int n);
    logic [71:0] t;
    t = v >> (8 * (n * n - 1 - (i * n + j)));
    return int'(t[7:0]);
  endfunction

  function automatic logic [71:0] pack(input int e[9], input int n);
    logic [71:0] r;
    r = '0;
    for (int x = 0; x < n * n; x++) r |= 72'(e[x] & 255) << (8 * (n * n - 1 - x));
    return r;
  endfunction

  function automatic logic [71:0] rand_mat(input int n, input int lo, input int hi);
    int e[9];
    for (int x = 0; x < 9; x++) e[x] = int'($urandom_range(hi, lo));
    return pack(e, n);
  endfunction

  // Reference: textbook triple sum per element, then wrap (mod 256) or clamp to 255.
  function automatic logic [71:0] ref_mult(input logic [71:0] a, input logic [71:0] b,
                                           input bit sat, input int n, output bit ov);
    int    e[9];
    longint s;
    ov = 1'b0;
    for (int x = 0; x < 9; x++) e[x] = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += longint'(get_el(a, i, k, n)) * longint'(get_el(b, k, j, n));
        if (s > 255) ov = 1'b1;
        e[i * n + j] = sat ? ((s > 255) ? 255 : int'(s)) : int'(s % 256);
      end
    end
    return pack(e, n);
  endfunction

  task automatic drive(input int n, input logic v, input logic [71:0] a, input logic [71:0] b,
                       input logic s);
    if (n == 2) begin
      in_valid2 = v; a2 = a[31:0]; b2 = b[31:0]; sat2 = s;
    end else begin
      in_valid3 = v; a3 = a; b3 = b; sat3 = s;
    end
  endtask

  function automatic logic rdy(input int n);
    return (n == 2) ? in_ready2 : in_ready3;
  endfunction

  function automatic logic ovld(input int n);
    return (n == 2) ? out_valid2 : out_valid3;
  endfunction

  function automatic logic [71:0] resv(input int n);
    return (n == 2) ? {40'd0, res2} : res3;
  endfunction

  function automatic logic ovfv(input int n);
    return (n == 2) ? ovf2 : ovf3;
  endfunction

  // One full operation with out_ready held high; operands are scrambled after acceptance.
  task automatic run_op(input int n, input logic [71:0] a, input logic [71:0] b, input logic s,
                        input string tag, output logic [71:0] got);
    logic [71:0] exp;
    bit          eov;
    int          w, lat, bad;
    exp = ref_mult(a, b, s, n, eov);
    @(negedge clk);
    out_ready2 = 1'b1;
    out_ready3 = 1'b1;
    drive(n, 1'b1, a, b, s);
    w = 0;
    while (!rdy(n) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".accept_ready"}, 72'(rdy(n)), 72'(1));
    @(negedge clk);
    drive(n, 1'b0, ~a, ~b, ~s);
    lat = 1;
    bad = 0;
    while (!ovld(n) && lat < 200) begin
      if (rdy(n)) bad++;
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 72'(lat), 72'(n * n * n + 1));
    check({tag, ".in_ready_busy"}, 72'(bad), 72'(0));
    got = resv(n);
    check({tag, ".result"}, got, exp);
    check({tag, ".ovf"}, 72'(ovfv(n)), 72'(eov));
    @(negedge clk);
    check({tag, ".ready_after"}, 72'(rdy(n)), 72'(1));
  endtask

  initial begin : main
    logic [71:0] got, ta, tb2, pa, pb, exp, exp2;
    logic [31:0] rr[2];
    logic        ro[2];
    bit          eov, eov2;
    int          w, bad, lat, nres, nacc, h_cyc, a_cyc;
    logic        s;

    reset = 1'b1;
    drive(2, 1'b0, '0, '0, 1'b0);
    drive(3, 1'b0, '0, '0, 1'b0);
    out_ready2 = 1'b0;
    out_ready3 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.in_ready", 72'(in_ready2), 72'(1));
    check("reset.out_valid", 72'(out_valid2), 72'(0));
    check("reset.result", 72'(res2), 72'(0));
    check("reset.ovf", 72'(ovf2), 72'(0));
    reset = 1'b0;

    // Directed basics.
    run_op(2, pack('{1, 2, 3, 4, 0, 0, 0, 0, 0}, 2), pack('{5, 6, 7, 8, 0, 0, 0, 0, 0}, 2), 1'b0, "basic", got);
    check("basic.const", got, pack('{19, 22, 43, 50, 0, 0, 0, 0, 0}, 2));
    run_op(2, pack('{200, 200, 0, 0, 0, 0, 0, 0, 0}, 2), pack('{2, 0, 2, 0, 0, 0, 0, 0, 0}, 2), 1'b0, "wrap", got);
    check("wrap.const", got, pack('{32, 0, 0, 0, 0, 0, 0, 0, 0}, 2));
    check("wrap.ovf_const", 72'(ovf2), 72'(1));
    run_op(2, pack('{200, 200, 0, 0, 0, 0, 0, 0, 0}, 2), pack('{2, 0, 2, 0, 0, 0, 0, 0, 0}, 2), 1'b1, "sat", got);
    check("sat.const", got, pack('{255, 0, 0, 0, 0, 0, 0, 0, 0}, 2));

    // N=3 identity.
    run_op(3, pack('{1, 0, 0, 0, 1, 0, 0, 0, 1}, 3), pack('{1, 2, 3, 4, 5, 6, 7, 8, 9}, 3), 1'b0, "ident3", got);
    check("ident3.const", got, pack('{1, 2, 3, 4, 5, 6, 7, 8, 9}, 3));

    // Randomized operations against the model.
    for (int it = 0; it < 6; it++) begin
      s = 1'($urandom_range(1, 0));
      run_op(2, rand_mat(2, 0, 255), rand_mat(2, 0, (it < 3) ? 15 : 255), s, $sformatf("rand2_%0d", it), got);
    end
    for (int it = 0; it < 3; it++) begin
      s = 1'($urandom_range(1, 0));
      run_op(3, rand_mat(3, 0, (it == 0) ? 9 : 255), rand_mat(3, 0, 255), s, $sformatf("rand3_%0d", it), got);
    end

    // Backpressure: stall in DONE while a new request and changing operands are presented.
    ta  = rand_mat(2, 0, 255);
    tb2 = rand_mat(2, 0, 255);
    pa  = rand_mat(2, 0, 255);
    pb  = rand_mat(2, 0, 255);
    exp = ref_mult(ta, tb2, 1'b0, 2, eov);
    @(negedge clk);
    out_ready2 = 1'b0;
    drive(2, 1'b1, ta, tb2, 1'b0);
    w = 0;
    while (!in_ready2 && w < 200) begin @(negedge clk); w++; end
    @(negedge clk);
    drive(2, 1'b0, ta, tb2, 1'b0);
    w = 0;
    while (!out_valid2 && w < 200) begin @(negedge clk); w++; end
    check("bp.reach_done", 72'(out_valid2), 72'(1));
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (res2 !== exp[31:0] || ovf2 !== eov || in_ready2 !== 1'b0 || out_valid2 !== 1'b1) bad++;
      drive(2, 1'b1, rand_mat(2, 0, 255), pb, 1'b1);
      @(negedge clk);
    end
    check("bp.stable_result", 72'(res2), exp);
    check("bp.stall_violations", 72'(bad), 72'(0));
    drive(2, 1'b1, pa, pb, 1'b1);
    out_ready2 = 1'b1;
    @(negedge clk);
    check("bp.ready_after_hs", 72'(in_ready2), 72'(1));
    check("bp.valid_after_hs", 72'(out_valid2), 72'(0));
    @(negedge clk);
    drive(2, 1'b0, '0, '0, 1'b0);
    check("bp.pending_accepted", 72'(in_ready2), 72'(0));
    exp = ref_mult(pa, pb, 1'b1, 2, eov);
    lat = 1;
    while (!out_valid2 && lat < 200) begin @(negedge clk); lat++; end
    check("bp.pending_latency", 72'(lat), 72'(9));
    check("bp.pending_result", 72'(res2), exp);
    check("bp.pending_ovf", 72'(ovf2), 72'(eov));
    @(negedge clk);

    // Reset in the third COMPUTE cycle; operands chosen so element [0][0] has overflowed by then.
    ta  = rand_mat(2, 128, 255);
    tb2 = rand_mat(2, 128, 255);
    drive(2, 1'b1, ta, tb2, 1'b0);
    w = 0;
    while (!in_ready2 && w < 200) begin @(negedge clk); w++; end
    @(negedge clk);
    drive(2, 1'b0, ta, tb2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst.pre_ovf", 72'(ovf2), 72'(1));
    reset = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 72'(in_ready2), 72'(1));
    check("rst.out_valid", 72'(out_valid2), 72'(0));
    check("rst.result", 72'(res2), 72'(0));
    check("rst.ovf", 72'(ovf2), 72'(0));
    reset = 1'b0;
    run_op(2, pack('{1, 1, 1, 1, 0, 0, 0, 0, 0}, 2), pack('{1, 1, 1, 1, 0, 0, 0, 0, 0}, 2), 1'b0, "ones", got);
    check("ones.const", got, pack('{2, 2, 2, 2, 0, 0, 0, 0, 0}, 2));

    // Back-to-back: in_valid stays high across two operand sets.
    ta  = rand_mat(2, 0, 255);
    tb2 = rand_mat(2, 0, 255);
    pa  = rand_mat(2, 0, 255);
    pb  = rand_mat(2, 0, 255);
    exp  = ref_mult(ta, tb2, 1'b0, 2, eov);
    exp2 = ref_mult(pa, pb, 1'b1, 2, eov2);
    @(negedge clk);
    out_ready2 = 1'b1;
    drive(2, 1'b1, ta, tb2, 1'b0);
    nres = 0; nacc = 0; h_cyc = -100; a_cyc = -200;
    rr[0] = '0; rr[1] = '0; ro[0] = 1'b0; ro[1] = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (in_valid2 && in_ready2) begin
        nacc++;
        if (nacc == 2) a_cyc = c;
      end
      if (out_valid2 && out_ready2) begin
        if (nres < 2) begin
          rr[nres] = res2;
          ro[nres] = ovf2;
        end
        nres++;
        if (nres == 1) h_cyc = c;
      end
      @(negedge clk);
      if (nacc == 1) drive(2, 1'b1, pa, pb, 1'b1);
      if (nacc >= 2) drive(2, 1'b0, pa, pb, 1'b1);
    end
    check("b2b.results", 72'(nres), 72'(2));
    check("b2b.accepts", 72'(nacc), 72'(2));
    check("b2b.gap", 72'(a_cyc - h_cyc), 72'(1));
    check("b2b.result0", 72'(rr[0]), exp);
    check("b2b.ovf0", 72'(ro[0]), 72'(eov));
    check("b2b.result1", 72'(rr[1]), exp2);
    check("b2b.ovf1", 72'(ro[1]), 72'(eov2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mat_mult_seq.md
Name: mat_mult_seq

Overview:
Parametrised sequential N x N matrix multiplier. It computes Result = A x B on packed DATA_W-bit unsigned elements using one multiply-accumulate per cycle. Both input and output use valid/ready handshakes. Each element can either wrap modulo 2^DATA_W or saturate, selected per operation. It sits between the host-facing register/stream interface and downstream consumers, and serves as the general-width, pipelined-handshake replacement for the fixed 2x2 8-bit combinational multiplier.

Parameters:
N, 2, matrix dimension (rows = cols), N >= 2
DATA_W, 8, element width of A, B and Result (unsigned)
ACC_W, 2*DATA_W+$clog2(N), accumulator width; derived, no internal overflow possible

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  A/B/sat_mode valid
in_ready  out  1  block can accept an operation
a_in  in  N*N*DATA_W  matrix A, row-major, element [0][0] in MSBs
b_in  in  N*N*DATA_W  matrix B, same packing
sat_mode  in  1  0 = wrap (keep low DATA_W bits), 1 = clamp to 2^DATA_W-1
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  N*N*DATA_W  A x B, same packing as a_in
ovf  out  1  some element of the current result exceeded 2^DATA_W-1

Behaviour:
- Clock is clk. Reset is reset: one clock domain, synchronous, active-high.
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, ovf 0, accumulator 0, indices 0.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready = 1.
  - On the edge where in_valid && in_ready: latch a_in, b_in and sat_mode into internal registers; clear the accumulator, i/j/k and ovf; go to COMPUTE.
- COMPUTE:
  - in_ready = 0.
  - One MAC per cycle: acc += A[i][k] * B[k][j]. k iterates innermost, then j, then i.
  - When k = N-1, the element write uses the final sum acc + product:
    - wrap: result[i][j] = sum[DATA_W-1:0].
    - sat: result[i][j] = min(sum, 2^DATA_W-1).
    - If sum > 2^DATA_W-1, ovf is set in either mode (sticky until the next acceptance).
  - After the write, the accumulator clears and k returns to 0.
  - After element [N-1][N-1] is written, go to DONE.
- Latency: if acceptance is at edge t, out_valid is first high in the cycle after edge t+N^3. That is N^3+1 cycles; 9 for N=2, 28 for N=3.
- DONE:
  - out_valid = 1; result and ovf are held stable.
  - On out_valid && out_ready: go to IDLE; in_ready rises the following cycle. There is no same-cycle bypass and no overlap of operations.
- Input changes after acceptance are ignored, since operands are latched.
- in_valid asserted while in_ready = 0 is ignored. Upstream holds in_valid/data until the handshake completes.
- result is updated element by element during COMPUTE but is only qualified by out_valid. The previous result is not preserved once a new operation is accepted.
- Reset mid-COMPUTE or mid-DONE: the partial result is discarded, all outputs take their reset values, and the block is in IDLE the next cycle.
- out_ready is ignored outside DONE.

Decomposition:
- Package mat_mult_pkg:
  - state enum (IDLE/COMPUTE/DONE);
  - function acc_width(N, DATA_W);
  - function sat_or_wrap(sum, mode) returning a DATA_W value;
  - function elem_idx(i, j, N) for packed-vector slicing.
- Sub-module mac_unit: DATA_W x DATA_W multiply plus ACC_W accumulator with clear and enable. It outputs the combinational sum (acc + product) and the registered acc. It is instantiated once.

Test Plan:
- N=2, wrap, A={1,2,3,4}, B={5,6,7,8}, out_ready=1 -> result={19,22,43,50}, ovf=0, out_valid exactly 9 cycles after the acceptance edge, in_ready 0 throughout.
- N=2, A={200,200,0,0}, B={2,0,2,0} -> wrap: result={32,0,0,0}, ovf=1; rerun with sat: result={255,0,0,0}, ovf=1.
- Backpressure: finish an op with out_ready=0 for 5 cycles while driving new in_valid and changing a_in -> result/ovf stable, in_ready=0, new op not accepted; raise out_ready -> handshake, in_ready=1 next cycle, pending op accepted.
- Reset in 3rd COMPUTE cycle -> next cycle state IDLE, out_valid=0, result=0, ovf=0, in_ready=1; following op A=B=all 1 (N=2) -> result={2,2,2,2}.
- N=3 build, A=identity, B={1..9}, wrap -> result={1..9}, ovf=0, latency 28 cycles.
- Back-to-back: in_valid held high with two operand sets, out_ready=1 -> exactly two results, second acceptance one cycle after first output handshake, both values correct.
